// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and writeback.
// Optional MEM_READY_EN adds a mem_ready handshake that stalls FETCH/MEM_READ/MEM_WRITE.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
`ifdef MEM_READY_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] opc,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_LUI
  } state_t;

  state_t r_state, w_next;
  logic   w_ready, w_taken;
  logic   w_pc_write, w_mem_write, w_ir_write, w_reg_write, w_done, w_illegal;

`ifdef MEM_READY_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  always_comb begin
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = neg;
      3'b101:  w_taken = ~neg;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (opc)
      OP_SW:   imm_src = 3'b001;
      OP_B:    imm_src = 3'b010;
      OP_LUI:  imm_src = 3'b011;
      OP_JAL:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_done      = 1'b0;
    w_illegal   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (w_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opc)
          OP_LW, OP_SW: w_next = S_MEM_ADR;
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_B:         w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_LUI:       w_next = S_LUI;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (opc == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        if (w_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src = 1'b1;
        if (w_ready) begin
          w_mem_write = 1'b1;
          w_done      = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        w_pc_write = w_taken;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        // PC <- PC+imm while ALUOut keeps oldPC+4 for the link writeback in ALU_WB
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALU_WB;
      end
      S_LUI: begin
        result_src  = 2'b11;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset holds state at FETCH, so enables must be masked or FETCH would write during reset.
  assign pc_write   = w_pc_write  & ~rst;
  assign mem_write  = w_mem_write & ~rst;
  assign ir_write   = w_ir_write  & ~rst;
  assign reg_write  = w_reg_write & ~rst;
  assign instr_done = w_done      & ~rst;
  assign illegal    = w_illegal   & ~rst;
endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Multi-cycle RV32I control unit: an FSM that sequences a shared-memory datapath (one ALU, one memory, IR, ALUOut and data registers) over 3-5 cycles per instruction.
- Drives the same control categories as the single-cycle main controller: ALU op class, imm select, result select, write enables. Adds fetch/PC sequencing and per-state mux selects.
- Sits between the IR/status flags and the multi-cycle datapath.

Parameters:
- none (opcode, ALU_op and imm_src encodings are fixed, below).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opc  in  7  IR[6:0]
- func3  in  3  IR[14:12], used for branch condition
- zero  in  1  ALU result == 0
- neg  in  1  ALU result sign bit (signed compare)
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR (and oldPC) load enable
- result_src  out  2  00 = ALUOut, 01 = mem data reg, 10 = ALU result, 11 = immediate
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = reg A
- alu_src_b  out  2  00 = reg B, 01 = imm, 10 = constant 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = LUI, 100 = JAL
- reg_write  out  1  register file write enable
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type, 11 = I-type
- instr_done  out  1  1-cycle pulse in the final state of each instruction
- illegal  out  1  1-cycle pulse in DECODE when the opcode is unknown

Behaviour:
- Opcodes: LW 0000011, SW 0100011, R 0110011, B 1100011, I 0010011, LUI 0110111, JAL 1101111.
- FSM states: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, LUI.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: LW/SW -> MEM_ADR; R -> EXEC_R; I -> EXEC_I; B -> BRANCH; JAL -> JAL; LUI -> LUI; other -> FETCH with illegal = 1.
  - MEM_ADR: LW -> MEM_READ, SW -> MEM_WRITE.
  - MEM_READ -> MEM_WB.
  - EXEC_R, EXEC_I, JAL -> ALU_WB.
  - MEM_WB, MEM_WRITE, ALU_WB, BRANCH, LUI -> FETCH.
- Latency: LW 5, SW 4, R 4, I 4, B 3, JAL 4, LUI 3, illegal 2 cycles.
- Outputs are Moore, decoded from state; every output not listed for a state is 0.
  - FETCH: ir_write = 1, pc_write = 1, a = 00, b = 10, alu_op = 00, result_src = 10.
  - DECODE: a = 01, b = 01, alu_op = 00 (branch target into ALUOut).
  - MEM_ADR: a = 10, b = 01, alu_op = 00.
  - MEM_READ: adr_src = 1.
  - MEM_WB: result_src = 01, reg_write = 1, instr_done = 1.
  - MEM_WRITE: adr_src = 1, mem_write = 1, instr_done = 1.
  - EXEC_R: a = 10, b = 00, alu_op = 10.
  - EXEC_I: a = 10, b = 01, alu_op = 11.
  - ALU_WB: result_src = 00, reg_write = 1, instr_done = 1.
  - BRANCH: a = 10, b = 00, alu_op = 01, result_src = 00, pc_write = taken, instr_done = 1.
  - JAL: a = 01, b = 10, alu_op = 00, result_src = 00, pc_write = 1.
  - LUI: result_src = 11, reg_write = 1, instr_done = 1.
- Branch taken, by func3: 000 zero; 001 !zero; 100 neg; 101 !neg; any other value never taken.
- imm_src is combinational from opc in every state: LW/I 000, SW 001, B 010, LUI 011, JAL 100, else 000.
- Reset: while rst = 1, state = FETCH and all enables (pc_write, ir_write, reg_write, mem_write, instr_done, illegal) are forced to 0. Reset asserted mid-instruction aborts it with no further writes. The first FETCH cycle is the first rising edge after rst deasserts.
- opc, func3, zero and neg are sampled only in the states that use them; changes in other states have no effect.

Optional Feature:
- Macro: MEM_READY_EN. Adds input mem_ready (1 bit).
- With the macro: FETCH, MEM_READ and MEM_WRITE hold state until mem_ready = 1.
  - The state's enables (ir_write, pc_write, mem_write) assert only in the cycle where mem_ready = 1.
  - mux selects stay stable while waiting.
  - instr_done for MEM_WRITE pulses only in its completing cycle.
- Without the macro: no mem_ready port; memory is treated as always ready.

Test Plan:
- rst = 1 for 3 cycles mid-LW, then release -> all enables 0 during reset; ir_write = 1, pc_write = 1 in the first cycle after release.
- LW (opc 0000011) -> states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB; reg_write = 1 and result_src = 01 only in cycle 5; instr_done in cycle 5.
- SW then R-type -> mem_write = 1, adr_src = 1 in cycle 4 of SW; R-type alu_op = 10 in EXEC_R, then reg_write in cycle 4.
- BEQ with zero = 1, then BNE with zero = 1 -> pc_write = 1 in BRANCH for BEQ; pc_write = 0 for BNE; each 3 cycles. BLT with neg = 1 -> taken.
- JAL then LUI -> JAL: pc_write = 1 in cycle 3, reg_write with result_src = 00 in cycle 4. LUI: reg_write with result_src = 11 in cycle 3.
- opc 1111111 -> illegal pulses in DECODE, no write enables, back to FETCH after 2 cycles. With MEM_READY_EN, mem_ready = 0 for 4 cycles in FETCH -> no ir_write until mem_ready = 1.
